uart_rx_byte: RTL and testbench
===============================

Name: uart_rx_byte

Overview:
- UART receiver that sits directly upstream of the memory controller.
- Deserialises 8N1 frames from the board's serial RX pin and presents each valid byte as rx_data with a single-cycle rx_done strobe.
- The memory controller uses that strobe as its write enable source.
- Mid-bit sampling, start-bit glitch rejection, and a framing-error indication.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per bit period (50 MHz / 115200); legal values 4 and up.
- D_WIDTH, 8, data bits per frame; LSB first.

Ports:
- clk  input  1  system clock
- n_rst  input  1  asynchronous, active-low reset
- rx  input  1  serial line, idle high, asynchronous to clk
- rx_data  output  D_WIDTH  last correctly received byte
- rx_done  output  1  one-cycle pulse, high when rx_data is updated
- frame_err  output  1  one-cycle pulse when a stop bit is sampled low
- busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset is asynchronous and active-low on n_rst; one clock domain, clk.
- Reset values:
  - rx_data = 0, rx_done = 0, frame_err = 0, busy = 0.
  - Both synchroniser flops = 1.
  - FSM = IDLE; bit counter = 0; cycle counter = 0.
- Synchroniser: rx passes through 2 flops to give rx_s. All decisions use rx_s only.
- Cycle counter width is $clog2(CLKS_PER_BIT). It clears on every state change.
- IDLE:
  - rx_s == 0 -> START.
- START:
  - Count to CLKS_PER_BIT/2 - 1 (integer division); this is the mid-start sample point.
  - rx_s == 0 at that point -> DATA.
  - rx_s == 1 at that point -> IDLE (glitch rejected). No outputs change.
- DATA:
  - Count to CLKS_PER_BIT - 1, then sample rx_s into a shift register, LSB first, and increment the bit counter.
  - After sample D_WIDTH -> STOP.
- STOP:
  - Count to CLKS_PER_BIT - 1, then sample rx_s.
  - rx_s == 1: load rx_data from the shift register, pulse rx_done, -> IDLE.
  - rx_s == 0: pulse frame_err, leave rx_data unchanged, no rx_done, -> WAIT_IDLE.
- WAIT_IDLE:
  - Stay until rx_s == 1, then -> IDLE. This prevents a break or stuck-low line from being read as a new start bit.
- Output timing:
  - rx_done and frame_err are registered and are high for exactly 1 clk.
  - They are never high together.
  - rx_data changes only in the same cycle rx_done is high, and holds its value until the next good frame.
- Latency: rx_done rises 2 + (CLKS_PER_BIT/2) + (D_WIDTH + 1)·CLKS_PER_BIT + 1 clk after the falling edge on rx (±1 clk for synchroniser phase).
- Back-to-back frames: a start bit arriving immediately after the stop sample must be accepted. IDLE needs 1 clk, which is absorbed by the half-bit start window.
- Reset mid-frame: the frame is abandoned immediately. No rx_done or frame_err may be produced for the partial frame after reset is released.
- busy = (state != IDLE), registered with the state.

Test Plan:
- CLKS_PER_BIT=16. Send 0x41 with a correct stop bit -> exactly one rx_done pulse at the computed latency; rx_data = 0x41; frame_err stays 0.
- Send 0xA5 then 0x3C back-to-back with no idle gap -> two rx_done pulses 160 clk apart; rx_data = 0xA5 then 0x3C.
- Pull rx low for 4 clk, then high -> FSM returns to IDLE; no rx_done, no frame_err; rx_data keeps its previous value.
- Send 0x7E with the stop bit driven 0, then hold rx low 50 clk, then high -> one frame_err pulse, no rx_done, rx_data unchanged, busy high until rx returns high. A following 0x55 frame -> rx_done, rx_data = 0x55.
- Assert n_rst during data bit 4 of a frame -> all outputs 0 immediately; after release, the line stays idle for 20 clk -> no pulses. A subsequent 0xC3 frame is received correctly.
- Send 0x00 and 0xFF -> rx_data = 0x00 then 0xFF, confirming LSB-first ordering and the all-zero frame not being mistaken for a break.

Source files
------------

// File: rtl/uart_rx_byte_if.sv
// Receiver-side bundle: the serial line into the block and the byte/strobe/status back out.
interface uart_rx_byte_if #(
  parameter int D_WIDTH = 8
);
  logic               rx;
  logic [D_WIDTH-1:0] rx_data;
  logic               rx_done;
  logic               frame_err;
  logic               busy;

  modport master (
    input  rx,
    output rx_data,
    output rx_done,
    output frame_err,
    output busy
  );

  modport slave (
    output rx,
    input  rx_data,
    input  rx_done,
    input  frame_err,
    input  busy
  );
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver, mid-bit sampling; rx_done ~3 + CLKS_PER_BIT/2 + (D_WIDTH+1)*CLKS_PER_BIT clk after the start edge.
// No backpressure: rx_done/frame_err are single-cycle strobes the consumer must take when they fire.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 434,
  parameter int D_WIDTH      = 8
) (
  input  logic           clk,
  input  logic           n_rst,
  uart_rx_byte_if.master bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(D_WIDTH + 1);

  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(D_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [D_WIDTH-1:0] shift_q, shift_d;
  logic [D_WIDTH-1:0] data_q, data_d;
  logic               done_q, done_d;
  logic               ferr_q, ferr_d;
  logic               busy_q;
  logic               rx_meta;
  logic               rx_s;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
    end
  end

  // cnt_d defaults to zero, so it only advances while waiting inside a state
  // and clears on every transition or sample point.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
        end
      end

      START: begin
        if (cnt_q == HALF_END) begin
          bit_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DATA: begin
        if (cnt_q == BIT_END) begin
          shift_d = D_WIDTH'({rx_s, shift_q} >> 1);
          bit_d   = bit_q + BIT_W'(1);
          if (bit_q == LAST_BIT) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      STOP: begin
        if (cnt_q == BIT_END) begin
          if (rx_s) begin
            data_d  = shift_q;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // A break or stuck-low line must go high before a new start is accepted.
      WAIT_IDLE: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_done   = done_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Randomised and directed frames against a frame-level scoreboard of expected strobes.
module tb_uart_rx_byte;

  localparam int CPB   = 16;
  localparam int DW    = 8;
  localparam int LAT   = 2 + CPB / 2 + (DW + 1) * CPB + 1;
  localparam int FRAME = (DW + 2) * CPB;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;
  int   cyc   = 0;
  int   n_chk = 0;
  int   n_err = 0;

  logic [7:0] exp_data  = 8'h00;
  logic [7:0] prev_data = 8'h00;

  int         exp_done_cyc[$];
  logic [7:0] exp_done_dat[$];
  int         exp_err_cyc[$];
  int         obs_done_cyc[$];
  logic [7:0] obs_done_dat[$];
  int         obs_err_cyc[$];

  uart_rx_byte_if #(.D_WIDTH(DW)) bus ();

  uart_rx_byte #(
    .CLKS_PER_BIT(CPB),
    .D_WIDTH     (DW)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Observe strobes away from the active edge.
  always @(negedge clk) begin
    if (n_rst) begin
      if (bus.rx_done) begin
        obs_done_cyc.push_back(cyc);
        obs_done_dat.push_back(bus.rx_data);
      end
      if (bus.frame_err) obs_err_cyc.push_back(cyc);
      if (bus.rx_done || bus.frame_err)
        chk("done_ferr_exclusive", 32'(bus.rx_done & bus.frame_err), 32'd0);
      if (bus.rx_data !== prev_data)
        chk("data_moves_only_with_done", 32'(bus.rx_done), 32'd1);
    end
    prev_data = bus.rx_data;
  end

  function automatic logic frame_bit(input logic [7:0] b, input bit stop_ok, input int idx);
    if (idx == 0)       return 1'b0;
    else if (idx <= DW) return b[idx-1];
    else                return stop_ok;
  endfunction

  // Drives up to ncyc clocks of a frame; a complete frame adds its expected outcome.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int ncyc);
    int fall = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      if (c == 0) fall = cyc;
      bus.rx = frame_bit(b, stop_ok, c / CPB);
    end
    if (ncyc >= FRAME) begin
      if (stop_ok) begin
        exp_done_cyc.push_back(fall + LAT);
        exp_done_dat.push_back(b);
        exp_data = b;
      end else begin
        exp_err_cyc.push_back(fall + LAT);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      bus.rx = 1'b1;
    end
  endtask

  task automatic line_low(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      bus.rx = 1'b0;
    end
  endtask

  task automatic check_events(input string tag);
    chk({tag, "_ndone"}, 32'(obs_done_cyc.size()), 32'(exp_done_cyc.size()));
    chk({tag, "_nferr"}, 32'(obs_err_cyc.size()), 32'(exp_err_cyc.size()));
    for (int i = 0; i < obs_done_cyc.size() && i < exp_done_cyc.size(); i++) begin
      chk({tag, "_done_cyc"}, 32'(obs_done_cyc[i]), 32'(exp_done_cyc[i]));
      chk({tag, "_done_dat"}, 32'(obs_done_dat[i]), 32'(exp_done_dat[i]));
    end
    for (int i = 0; i < obs_err_cyc.size() && i < exp_err_cyc.size(); i++)
      chk({tag, "_ferr_cyc"}, 32'(obs_err_cyc[i]), 32'(exp_err_cyc[i]));
    chk({tag, "_rx_data"}, 32'(bus.rx_data), 32'(exp_data));
    exp_done_cyc.delete();
    exp_done_dat.delete();
    exp_err_cyc.delete();
    obs_done_cyc.delete();
    obs_done_dat.delete();
    obs_err_cyc.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    bit         ok;

    bus.rx = 1'b1;
    n_rst  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rx_data", 32'(bus.rx_data), 32'd0);
    chk("rst_rx_done", 32'(bus.rx_done), 32'd0);
    chk("rst_frame_err", 32'(bus.frame_err), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    n_rst = 1'b1;
    idle(5);

    // Single good frame, exact latency.
    send_frame(8'h41, 1'b1, FRAME);
    idle(20);
    check_events("single");
    chk("single_busy_after", 32'(bus.busy), 32'd0);

    // Back-to-back frames with no idle gap.
    send_frame(8'hA5, 1'b1, FRAME);
    send_frame(8'h3C, 1'b1, FRAME);
    idle(20);
    check_events("b2b");

    // Short start glitch is rejected.
    line_low(4);
    chk("glitch_busy", 32'(bus.busy), 32'd1);
    idle(20);
    chk("glitch_busy_after", 32'(bus.busy), 32'd0);
    check_events("glitch");

    // Bad stop bit followed by a held-low line, then a good frame.
    send_frame(8'h7E, 1'b0, FRAME);
    line_low(50);
    chk("break_busy", 32'(bus.busy), 32'd1);
    idle(5);
    chk("break_busy_after", 32'(bus.busy), 32'd0);
    send_frame(8'h55, 1'b1, FRAME);
    idle(20);
    check_events("ferr");

    // Reset in the middle of data bit 4.
    send_frame(8'h99, 1'b1, 5 * CPB + 8);
    chk("midrst_busy_pre", 32'(bus.busy), 32'd1);
    n_rst = 1'b0;
    #1;
    chk("midrst_rx_data", 32'(bus.rx_data), 32'd0);
    chk("midrst_rx_done", 32'(bus.rx_done), 32'd0);
    chk("midrst_frame_err", 32'(bus.frame_err), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    bus.rx   = 1'b1;
    exp_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    n_rst = 1'b1;
    idle(20);
    check_events("midrst_quiet");
    send_frame(8'hC3, 1'b1, FRAME);
    idle(20);
    check_events("midrst_c3");

    // All-zero and all-one payloads.
    send_frame(8'h00, 1'b1, FRAME);
    idle(3);
    send_frame(8'hFF, 1'b1, FRAME);
    idle(20);
    check_events("zero_ones");

    // Random frames, gaps, bad stops and glitches.
    for (int i = 0; i < 30; i++) begin
      b  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 5) != 0);
      send_frame(b, ok, FRAME);
      idle(ok ? int'($urandom_range(0, 12)) : int'($urandom_range(2, 12)));
      if ($urandom_range(0, 7) == 0) begin
        line_low(int'($urandom_range(1, 6)));
        idle(16);
      end
    end
    idle(20);
    check_events("rand");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
